// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer
// Sweeps a 3-input gate network through all eight input vectors {A,B,C}.
// Each vector is held for SETTLE_CYCLES cycles, then f_in is sampled on the
// edge that ends the following SAMPLE cycle. The captured truth table is
// compared bit-by-bit against EXPECTED.
//
// Handshake: start is a level request with no ready. It is accepted on any
// rising edge where the FSM is in IDLE or DONE. While a sweep runs
// (busy=1), start is ignored.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   start        in   sweep request (sampled in IDLE/DONE only)
//   f_in         in   output of the gate network
//   abc          out  drive to network: abc[2]=A, abc[1]=B, abc[0]=C
//   busy         out  sweep in progress
//   done         out  sweep finished; held until next accepted start/reset
//   truth_table  out  bit i = f_in sampled for vector i
//   fail_count   out  number of mismatching vectors (0..8)
//   first_fail   out  index of first mismatching vector (0 when none)
//   pass         out  done && fail_count==0
//   state_dbg    out  current FSM state (debug)
module truth_table_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [7:0]  EXPECTED      = 8'h0F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       f_in,
  output logic [2:0] abc,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth_table,
  output logic [3:0] fail_count,
  output logic [2:0] first_fail,
  output logic       pass,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_idx;
  logic [3:0] r_cnt;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_truth_table;
  logic [3:0] r_fail_count;
  logic [2:0] r_first_fail;
  logic       r_pass;

  logic       w_accept;
  logic       w_settle_last;
  logic       w_mismatch;
  logic       w_last_vec;

  always_comb begin
    w_accept      = start && ((r_state == IDLE) || (r_state == DONE));
    w_settle_last = (r_cnt == SETTLE_LAST);
    w_mismatch    = (f_in != EXPECTED[r_idx]);
    w_last_vec    = (r_idx == 3'd7);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:   if (w_accept) w_state_next = SETTLE;
      SETTLE: if (w_settle_last) w_state_next = SAMPLE;
      SAMPLE: w_state_next = w_last_vec ? DONE : SETTLE;
      DONE:   if (w_accept) w_state_next = SETTLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: vector index (which is also the abc drive), settle counter,
  // and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx         <= 3'd0;
      r_cnt         <= 4'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_truth_table <= 8'd0;
      r_fail_count  <= 4'd0;
      r_first_fail  <= 3'd0;
      r_pass        <= 1'b0;
    end else if (w_accept) begin
      r_idx         <= 3'd0;
      r_cnt         <= 4'd0;
      r_busy        <= 1'b1;
      r_done        <= 1'b0;
      r_truth_table <= 8'd0;
      r_fail_count  <= 4'd0;
      r_first_fail  <= 3'd0;
      r_pass        <= 1'b0;
    end else begin
      case (r_state)
        SETTLE: begin
          r_cnt <= w_settle_last ? 4'd0 : r_cnt + 4'd1;
        end
        SAMPLE: begin
          r_truth_table[r_idx] <= f_in;
          if (w_mismatch) begin
            // Eight vectors at most, so the guard only documents the ceiling.
            if (r_fail_count < 4'd8) r_fail_count <= r_fail_count + 4'd1;
            if (r_fail_count == 4'd0) r_first_fail <= r_idx;
          end
          if (w_last_vec) begin
            // abc stays at 7 through DONE.
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= (r_fail_count == 4'd0) && !w_mismatch;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign abc         = r_idx;
  assign busy        = r_busy;
  assign done        = r_done;
  assign truth_table = r_truth_table;
  assign fail_count  = r_fail_count;
  assign first_fail  = r_first_fail;
  assign pass        = r_pass & r_done;
  assign state_dbg   = r_state;

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
Controller that sweeps a 3-input combinational gate network through all 8 input vectors. It drives A/B/C, waits a settle interval, then samples the network output. It accumulates an 8-bit truth table and compares it against an expected table. It sits between the stimulus side (start request) and the gate datapath, replacing hand-written vector lists in benches with a clocked self-check.

Parameters:
SETTLE_CYCLES, 1, cycles each vector is held before sampling; legal range 1..15
EXPECTED, 8'h0F, golden truth table, bit i = expected output for vector i = {A,B,C}; default matches out = (!A & (B|C)) | !(A|B)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a sweep; sampled in IDLE and DONE only
f_in  input  1  output of the gate network under control
abc  output  3  drive to network: abc[2]=A, abc[1]=B, abc[0]=C
busy  output  1  high while a sweep is in progress
done  output  1  high in DONE, held until the next accepted start or reset
truth_table  output  8  captured outputs, bit i = f_in sampled for vector i
fail_count  output  4  number of vectors where f_in != EXPECTED[i] (0..8)
first_fail  output  3  index of the first mismatching vector; 0 when none
pass  output  1  done && fail_count==0

Behaviour:
- Reset (async assert, any state): state=IDLE, abc=0, busy=0, done=0, truth_table=0, fail_count=0, first_fail=0, pass=0, settle counter=0. Registers hold reset values while reset is high. Sampling of start resumes on the first rising edge after deassert.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: on an edge with start=1, go to SETTLE. Same edge: idx=0, abc=0, truth_table=0, fail_count=0, first_fail=0, busy=1, settle counter=0.
- SETTLE: abc=idx held stable. Counter increments each cycle. When counter==SETTLE_CYCLES-1, go to SAMPLE and clear the counter.
- SAMPLE: at the rising edge, set truth_table[idx] <= f_in.
  - If f_in != EXPECTED[idx], fail_count increments.
  - If this is the first mismatch (fail_count was 0), set first_fail <= idx.
- SAMPLE exit:
  - If idx==7: go to DONE, with busy=0, done=1 and abc unchanged at 7.
  - Otherwise: idx=idx+1, abc=idx+1, go to SETTLE.
- Timing: each vector occupies SETTLE_CYCLES+1 cycles. done rises exactly 8*(SETTLE_CYCLES+1) cycles after the edge that accepted start (16 cycles for the default).
- abc changes only on the edge leaving SAMPLE, or on accept of a new start (to 0). It never changes within a vector's SETTLE/SAMPLE window.
- idx is 3 bits. There is no wrap past 7; the sweep terminates at 7.
- start while busy (SETTLE/SAMPLE) is ignored: no restart, no state change.
- DONE: outputs hold. start=1 behaves as in IDLE and clears the results on the same edge, so done drops and busy rises together.
- start held high continuously: back-to-back sweeps. DONE lasts exactly one cycle before the restart edge.
- pass is registered. It is valid only while done=1 and is forced 0 otherwise.
- fail_count saturates at 8; it cannot exceed 8 by construction.

Test Plan:
1. Reset, then start pulse for 1 cycle; f_in driven by the AND/OR/NOT network with the default EXPECTED -> abc steps 0..7 every 2 cycles, done at cycle 16, truth_table=8'h0F, fail_count=0, pass=1.
2. f_in tied to 0 -> truth_table=8'h00, fail_count=4, first_fail=0, pass=0. Then f_in tied to 1 -> truth_table=8'hFF, fail_count=4, first_fail=4.
3. start pulsed again at cycle 5 of a sweep -> ignored; done still at cycle 16 relative to the first start; abc sequence unbroken.
4. reset asserted mid-sweep while abc=3 (between edges) -> immediately abc=0, busy=0, truth_table=0. A subsequent start completes a normal sweep with pass=1.
5. SETTLE_CYCLES=3 -> abc holds each value 4 cycles; done at cycle 32; f_in sampled on the 4th cycle of each vector, verified by glitching f_in during the first 3 cycles with no effect.
6. start held high from DONE -> results cleared on the next edge, done low for 16 cycles, second sweep yields identical truth_table=8'h0F.
